// File: rtl/issue_pkg.sv
// Shared types and sizes for the issue controller slice.
// Optional feature macro used by the slice: ISSUE_WB_BYPASS_EN.
package issue_pkg;

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned REG_AW   = 5;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        SERIAL = 2'd2
    } state_e;

endpackage

// File: rtl/issue_if.sv
// Decoder-to-issue handshake bundle: decoded instruction fields plus valid/ready.
interface issue_if;
    import issue_pkg::*;

    logic              id_valid_i;
    logic              id_ready_o;
    logic              rs1_used_i;
    logic              rs2_used_i;
    logic [REG_AW-1:0] rs1_addr_i;
    logic [REG_AW-1:0] rs2_addr_i;
    logic [REG_AW-1:0] rd_addr_i;
    logic              rd_we_i;
    logic              is_ecall_i;
    logic              is_mret_i;

    modport master (
        output id_valid_i, rs1_used_i, rs2_used_i, rs1_addr_i, rs2_addr_i,
               rd_addr_i, rd_we_i, is_ecall_i, is_mret_i,
        input  id_ready_o
    );

    modport slave (
        input  id_valid_i, rs1_used_i, rs2_used_i, rs1_addr_i, rs2_addr_i,
               rd_addr_i, rd_we_i, is_ecall_i, is_mret_i,
        output id_ready_o
    );

endinterface

// File: rtl/issue_scoreboard.sv
// Pending-write scoreboard with set on issue, clear on retire.
// ISSUE_WB_BYPASS_EN: lookups ignore a bit being cleared in the same cycle.
module issue_scoreboard
    import issue_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                set_i,
    input  logic [REG_AW-1:0]   set_addr_i,
    input  logic                clr_i,
    input  logic [REG_AW-1:0]   clr_addr_i,
    input  logic [REG_AW-1:0]   rs1_addr_i,
    input  logic [REG_AW-1:0]   rs2_addr_i,
    input  logic [REG_AW-1:0]   rd_addr_i,
    output logic                rs1_busy_o,
    output logic                rs2_busy_o,
    output logic                rd_busy_o,
    output logic [NUM_REGS-1:0] busy_o
);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [NUM_REGS-1:0] set_mask, clr_mask, bsy;

    // x0 is never tracked, so bit 0 can never be set.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_i && set_addr_i != '0) set_mask[set_addr_i] = 1'b1;
        if (clr_i && clr_addr_i != '0) clr_mask[clr_addr_i] = 1'b1;
    end

    // Set wins over clear so a same-cycle reissue to the retiring rd stays pending.
    assign busy_d = (busy_q & ~clr_mask) | set_mask;

`ifdef ISSUE_WB_BYPASS_EN
    assign bsy = busy_q & ~clr_mask;
`else
    assign bsy = busy_q;
`endif

    assign rs1_busy_o = bsy[rs1_addr_i];
    assign rs2_busy_o = bsy[rs2_addr_i];
    assign rd_busy_o  = bsy[rd_addr_i];
    assign busy_o     = busy_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) busy_q <= '0;
        else         busy_q <= busy_d;
    end

endmodule

// File: rtl/issue_ctrl.sv
// Issue controller: hazard/in-flight/serialization gating of decoded instructions.
// ISSUE_WB_BYPASS_EN enables same-cycle writeback bypass in the scoreboard.
module issue_ctrl
    import issue_pkg::*;
#(
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    issue_if.slave                                id,
    input  logic                                  flush_i,
    input  logic                                  trap_done_i,
    input  logic                                  retire_valid_i,
    input  logic                                  retire_we_i,
    input  logic [REG_AW-1:0]                     retire_rd_i,
    output logic                                  issue_o,
    output logic [NUM_REGS-1:0]                   busy_o,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]     inflight_o,
    output logic                                  serial_o
);

    localparam int unsigned      IW      = $clog2(MAX_INFLIGHT + 1);
    localparam logic [IW-1:0]    MAX_CNT = IW'(MAX_INFLIGHT);

    state_e        state_q;
    logic          serial_q;
    logic [IW-1:0] inflight_q, inflight_d;
    logic          rs1_busy, rs2_busy, rd_busy;
    logic          raw, waw, permit, ready, issue, serializing, retire_ok;

    issue_scoreboard u_sb (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .set_i      (issue & id.rd_we_i),
        .set_addr_i (id.rd_addr_i),
        .clr_i      (retire_valid_i & retire_we_i),
        .clr_addr_i (retire_rd_i),
        .rs1_addr_i (id.rs1_addr_i),
        .rs2_addr_i (id.rs2_addr_i),
        .rd_addr_i  (id.rd_addr_i),
        .rs1_busy_o (rs1_busy),
        .rs2_busy_o (rs2_busy),
        .rd_busy_o  (rd_busy),
        .busy_o     (busy_o)
    );

    assign serializing = id.is_ecall_i | id.is_mret_i;
    assign raw = (id.rs1_used_i && id.rs1_addr_i != '0 && rs1_busy)
               | (id.rs2_used_i && id.rs2_addr_i != '0 && rs2_busy);
    assign waw = id.rd_we_i && id.rd_addr_i != '0 && rd_busy;

    always_comb begin
        permit = 1'b0;
        unique case (state_q)
            RUN:     permit = !serializing || inflight_q == '0;
            DRAIN:   permit = serializing && inflight_q == '0;
            SERIAL:  permit = 1'b0;
            default: permit = 1'b0;
        endcase
    end

    // Registered count gates issue, so a same-cycle retire cannot free a slot.
    assign ready = rst_ni & ~flush_i & ~raw & ~waw & (inflight_q < MAX_CNT) & permit;
    assign issue = id.id_valid_i & ready;

    assign id.id_ready_o = ready;
    assign issue_o       = issue;
    assign inflight_o    = inflight_q;
    assign serial_o      = serial_q;

    assign retire_ok = retire_valid_i && inflight_q != '0;

    always_comb begin
        inflight_d = inflight_q;
        if (issue && !retire_ok)      inflight_d = inflight_q + IW'(1);
        else if (!issue && retire_ok) inflight_d = inflight_q - IW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) inflight_q <= '0;
        else         inflight_q <= inflight_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= RUN;
            serial_q <= 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (id.id_valid_i && serializing && !flush_i) begin
                        if (issue) begin
                            state_q  <= SERIAL;
                            serial_q <= 1'b1;
                        end else if (inflight_q != '0) begin
                            state_q  <= DRAIN;
                            serial_q <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (flush_i) begin
                        state_q  <= RUN;
                        serial_q <= 1'b0;
                    end else if (issue) begin
                        state_q  <= SERIAL;
                        serial_q <= 1'b1;
                    end
                end
                SERIAL: begin
                    if (trap_done_i) begin
                        state_q  <= RUN;
                        serial_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= RUN;
                    serial_q <= 1'b0;
                end
            endcase
        end
    end

    a_no_retire_underflow: assert property (
        @(posedge clk_i) disable iff (!rst_ni) retire_valid_i |-> inflight_q != '0
    );

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl; expected values queued at drive time, popped at check.
// Honours ISSUE_WB_BYPASS_EN for the bypass-dependent expectations.
module tb_issue_ctrl;
    import issue_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush, trap_done, ret_v, ret_we;
    logic [4:0]  ret_rd;
    logic        issue;
    logic [31:0] busy;
    logic [2:0]  inflight;
    logic        serial;

    issue_if u_if();

    issue_ctrl #(.MAX_INFLIGHT(4)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .id             (u_if),
        .flush_i        (flush),
        .trap_done_i    (trap_done),
        .retire_valid_i (ret_v),
        .retire_we_i    (ret_we),
        .retire_rd_i    (ret_rd),
        .issue_o        (issue),
        .busy_o         (busy),
        .inflight_o     (inflight),
        .serial_o       (serial)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t expq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic exp_push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        expq.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        total++;
        if (expq.size() == 0) begin
            bad++;
            $error("FAIL queue_empty observed=%h", obs);
            return;
        end
        e = expq.pop_front();
        assert (obs === e.val) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
        end
    endtask

    task automatic idle();
        u_if.id_valid_i = 1'b0;
        u_if.rs1_used_i = 1'b0;
        u_if.rs2_used_i = 1'b0;
        u_if.rs1_addr_i = '0;
        u_if.rs2_addr_i = '0;
        u_if.rd_addr_i  = '0;
        u_if.rd_we_i    = 1'b0;
        u_if.is_ecall_i = 1'b0;
        u_if.is_mret_i  = 1'b0;
        flush     = 1'b0;
        trap_done = 1'b0;
        ret_v     = 1'b0;
        ret_we    = 1'b0;
        ret_rd    = '0;
    endtask

    task automatic offer(input logic [4:0] rd, input logic we, input logic [4:0] rs1,
                         input logic u1, input logic ecall, input logic mret);
        u_if.id_valid_i = 1'b1;
        u_if.rd_addr_i  = rd;
        u_if.rd_we_i    = we;
        u_if.rs1_addr_i = rs1;
        u_if.rs1_used_i = u1;
        u_if.is_ecall_i = ecall;
        u_if.is_mret_i  = mret;
    endtask

    task automatic retire(input logic [4:0] rd, input logic we);
        ret_v  = 1'b1;
        ret_we = we;
        ret_rd = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshake check: expects ready, and issue only when an instruction is offered.
    task automatic chk_hs(input string t, input logic r);
        exp_push({t, "_ready"}, {31'd0, r});
        exp_push({t, "_issue"}, {31'd0, r & u_if.id_valid_i});
        #2;
        check({31'd0, u_if.id_ready_o});
        check({31'd0, issue});
    endtask

    task automatic chk_st(input string t, input logic [31:0] b, input logic [2:0] n, input logic s);
        exp_push({t, "_busy"}, b);
        exp_push({t, "_inflight"}, {29'd0, n});
        exp_push({t, "_serial"}, {31'd0, s});
        check(busy);
        check({29'd0, inflight});
        check({31'd0, serial});
    endtask

    initial begin
        idle();
        offer(5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        chk_hs("reset", 1'b0);
        chk_st("reset", 32'h0, 3'd0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        idle();
        tick();

        // RAW on x5
        idle(); offer(5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        chk_hs("raw_w", 1'b1); tick();
        chk_st("raw_w", 32'h20, 3'd1, 1'b0);
        idle(); offer(5'd6, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        chk_hs("raw_stall", 1'b0); tick();
        chk_st("raw_stall", 32'h20, 3'd1, 1'b0);
        retire(5'd5, 1'b1);
`ifdef ISSUE_WB_BYPASS_EN
        chk_hs("raw_ret", 1'b1); tick();
        chk_st("raw_byp", 32'h40, 3'd1, 1'b0);
`else
        chk_hs("raw_ret", 1'b0); tick();
        chk_st("raw_nobyp", 32'h0, 3'd0, 1'b0);
        ret_v = 1'b0;
        chk_hs("raw_next", 1'b1); tick();
        chk_st("raw_next", 32'h40, 3'd1, 1'b0);
`endif
        idle(); retire(5'd6, 1'b1); tick();
        chk_st("raw_done", 32'h0, 3'd0, 1'b0);

        // x0 writers and in-flight limit
        for (int i = 0; i < 4; i++) begin
            idle(); offer(5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
            chk_hs("x0_fill", 1'b1); tick();
        end
        chk_st("x0_full", 32'h0, 3'd4, 1'b0);
        idle(); offer(5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0); retire(5'd0, 1'b0);
        chk_hs("x0_full_ret", 1'b0); tick();
        chk_st("x0_full_ret", 32'h0, 3'd3, 1'b0);
        idle(); offer(5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        chk_hs("x0_fifth", 1'b1); tick();
        idle(); offer(5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        chk_hs("x0_sixth_blk", 1'b0); tick();
        chk_st("x0_sixth_blk", 32'h0, 3'd4, 1'b0);
        retire(5'd0, 1'b0);
        chk_hs("x0_sixth_ret", 1'b0); tick();
        ret_v = 1'b0;
        chk_hs("x0_sixth", 1'b1); tick();
        chk_st("x0_sixth", 32'h0, 3'd4, 1'b0);
        idle(); retire(5'd0, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        idle();
        chk_st("x0_drain", 32'h0, 3'd0, 1'b0);

        // WAW on x7
        idle(); offer(5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        chk_hs("waw_first", 1'b1); tick();
        chk_st("waw_first", 32'h80, 3'd1, 1'b0);
        chk_hs("waw_stall", 1'b0); tick();
        chk_st("waw_stall", 32'h80, 3'd1, 1'b0);
        retire(5'd7, 1'b1);
`ifdef ISSUE_WB_BYPASS_EN
        chk_hs("waw_ret", 1'b1); tick();
        chk_st("waw_ret", 32'h80, 3'd1, 1'b0);
`else
        chk_hs("waw_ret", 1'b0); tick();
        chk_st("waw_ret", 32'h0, 3'd0, 1'b0);
        ret_v = 1'b0;
        chk_hs("waw_next", 1'b1); tick();
        chk_st("waw_next", 32'h80, 3'd1, 1'b0);
`endif
        idle(); retire(5'd7, 1'b1); tick();
        chk_st("waw_done", 32'h0, 3'd0, 1'b0);

        // ecall drain / serial / trap_done
        idle(); offer(5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        chk_hs("ser_w1", 1'b1); tick();
        idle(); offer(5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        chk_hs("ser_w2", 1'b1); tick();
        chk_st("ser_pre", 32'h6, 3'd2, 1'b0);
        idle(); offer(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk_hs("ecall_run", 1'b0); tick();
        chk_st("ecall_drain", 32'h6, 3'd2, 1'b1);
        retire(5'd1, 1'b1);
        chk_hs("ecall_d1", 1'b0); tick();
        chk_st("ecall_d1", 32'h4, 3'd1, 1'b1);
        retire(5'd2, 1'b1);
        chk_hs("ecall_d2", 1'b0); tick();
        chk_st("ecall_d2", 32'h0, 3'd0, 1'b1);
        ret_v = 1'b0;
        chk_hs("ecall_issue", 1'b1); tick();
        chk_st("ecall_serial", 32'h0, 3'd1, 1'b1);
        idle(); offer(5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0); retire(5'd0, 1'b0);
        chk_hs("serial_blk", 1'b0); tick();
        chk_st("serial_blk", 32'h0, 3'd0, 1'b1);
        ret_v = 1'b0; flush = 1'b1;
        chk_hs("serial_flush", 1'b0); tick();
        chk_st("serial_flush", 32'h0, 3'd0, 1'b1);
        flush = 1'b0; trap_done = 1'b1;
        chk_hs("serial_trap", 1'b0); tick();
        chk_st("serial_trap", 32'h0, 3'd0, 1'b0);
        trap_done = 1'b0;
        chk_hs("run_again", 1'b1); tick();
        chk_st("run_again", 32'h200, 3'd1, 1'b0);
        idle(); retire(5'd9, 1'b1); tick();
        chk_st("run_done", 32'h0, 3'd0, 1'b0);

        // flush while draining for mret
        idle(); offer(5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        chk_hs("fl_w", 1'b1); tick();
        idle(); offer(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        chk_hs("mret_run", 1'b0); tick();
        chk_st("mret_drain", 32'h8, 3'd1, 1'b1);
        flush = 1'b1;
        chk_hs("fl_drain", 1'b0); tick();
        chk_st("fl_drain", 32'h8, 3'd1, 1'b0);
        idle(); retire(5'd3, 1'b1); tick();
        chk_st("fl_done", 32'h0, 3'd0, 1'b0);

        // asynchronous reset mid-run
        idle(); offer(5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        chk_hs("mr_w2", 1'b1); tick();
        idle(); offer(5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        chk_hs("mr_w5", 1'b1); tick();
        chk_st("mr_pre", 32'h24, 3'd2, 1'b0);
        idle(); offer(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk_hs("mr_ecall", 1'b0); tick();
        chk_st("mr_drain", 32'h24, 3'd2, 1'b1);
        idle(); rst_n = 1'b0;
        #1;
        chk_st("mr_reset", 32'h0, 3'd0, 1'b0);
        offer(5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        chk_hs("mr_reset", 1'b0);
        tick();
        rst_n = 1'b1;
        chk_hs("mr_release", 1'b1); tick();
        chk_st("mr_release", 32'h10, 3'd1, 1'b0);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
